piso_serial_tx: RTL

//   Parallel-in/serial-out transmitter for the emulator's serial link.

---
 rtl/piso_serial_tx.sv | 86 ++++++++
 1 files changed

// File: rtl/piso_serial_tx.sv
// Parallel-in/serial-out link transmitter: bit 0 of a word appears on sdo the cycle after accept, done pulses after the last bit.
// No queueing: ready is low from accept until the cycle after done; stall freezes the shift in place.
module piso_serial_tx #(
   parameter int WIDTH      = 8,
   parameter bit LSB_FIRST  = 1'b1,
   parameter bit IDLE_LEVEL = 1'b1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [WIDTH-1:0]           data,
   input  logic                       valid,
   output logic                       ready,
   input  logic                       stall,
   output logic                       sdo,
   output logic                       bit_valid,
   output logic                       busy,
   output logic                       done,
   output logic [$clog2(WIDTH+1)-1:0] bits_left
);

   localparam int CW = $clog2(WIDTH+1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_DONE
   } state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] shreg, shreg_nxt;
   logic [CW-1:0]    cnt_nxt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         shreg     <= '0;
         bits_left <= '0;
      end else begin
         state     <= state_nxt;
         shreg     <= shreg_nxt;
         bits_left <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      shreg_nxt = shreg;
      cnt_nxt   = bits_left;
      ready     = 1'b0;
      bit_valid = 1'b0;
      busy      = 1'b1;
      done      = 1'b0;
      sdo       = IDLE_LEVEL;
      case (state)
         ST_IDLE: begin
            ready = 1'b1;
            busy  = 1'b0;
            if (valid) begin
               shreg_nxt = data;
               cnt_nxt   = CW'(WIDTH);
               state_nxt = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            bit_valid = 1'b1;
            sdo       = LSB_FIRST ? shreg[0] : shreg[WIDTH-1];
            // stall freezes register, count and state together
            if (!stall) begin
               shreg_nxt = LSB_FIRST ? (shreg >> 1) : (shreg << 1);
               cnt_nxt   = bits_left - CW'(1);
               if (bits_left == CW'(1)) begin
                  state_nxt = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            done      = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

endmodule
